// File: rtl/count_checker.sv
// count_checker: read-side consumer for async_fifo.
// Drains the FIFO and checks the incrementing count sequence from
// count_feeder (wrapping modulo 2^DATA_WIDTH). Reports received word count,
// saturating error count, a sticky error flag with the first mismatch
// captured, and sequence lock status, all in the r_clk domain.
//
// Optional feature: define COUNT_CHECKER_THROTTLE_EN to limit reads to
// THROTTLE_ON out of every THROTTLE_PERIOD cycles, so the FIFO fills and the
// full/empty paths are exercised. Default build reads whenever data is there.
module count_checker #(
  parameter int DATA_WIDTH      = 8,
  parameter int CNT_WIDTH       = 32,
  parameter int ERR_WIDTH       = 16,
  parameter int THROTTLE_PERIOD = 8,
  parameter int THROTTLE_ON     = 3
) (
  input  logic                  r_clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  resync,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] r_out,
  input  logic                  r_empty,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic                  err_flag,
  output logic [DATA_WIDTH-1:0] first_exp,
  output logic [DATA_WIDTH-1:0] first_got
);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

  state_t                r_state;
  logic                  r_rd_pend;
  logic [DATA_WIDTH-1:0] r_exp;
  logic                  r_locked;
  logic [CNT_WIDTH-1:0]  r_word_count;
  logic [ERR_WIDTH-1:0]  r_err_count;
  logic                  r_err_flag;
  logic [DATA_WIDTH-1:0] r_first_exp;
  logic [DATA_WIDTH-1:0] r_first_got;
  logic                  w_thr_ok;
  logic                  w_mismatch;

`ifdef COUNT_CHECKER_THROTTLE_EN
  localparam int TC_W = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(THROTTLE_PERIOD - 1);
  // One extra bit so THROTTLE_ON == THROTTLE_PERIOD (a power of two) still fits.
  localparam logic [TC_W:0]   THR_ON  = (TC_W + 1)'(THROTTLE_ON);

  logic [TC_W-1:0] r_tc;

  // Free-running throttle window counter; advances every cycle regardless of en.
  always_ff @(posedge r_clk) begin
    if (rst) begin
      r_tc <= '0;
    end else if (r_tc == TC_LAST) begin
      r_tc <= '0;
    end else begin
      r_tc <= r_tc + 1'b1;
    end
  end

  assign w_thr_ok = ({1'b0, r_tc} < THR_ON);
`else
  assign w_thr_ok = 1'b1;
`endif

  // NOTE: r_en is a pure continuous assignment of its inputs, so no storage
  // can be inferred; rst gates it so nothing is read while the block is held.
  assign r_en = en & ~r_empty & w_thr_ok & ~rst;

  assign w_mismatch = (r_out != r_exp);

  // Lock/check state machine: tracks pending reads and scores each received word.
  always_ff @(posedge r_clk) begin
    // NOTE: every register, including the captured first_* values, is cleared
    // by the synchronous reset so outputs are all-zero one cycle after rst.
    if (rst) begin
      r_state      <= ST_SYNC;
      r_rd_pend    <= 1'b0;
      r_exp        <= '0;
      r_locked     <= 1'b0;
      r_word_count <= '0;
      r_err_count  <= '0;
      r_err_flag   <= 1'b0;
      r_first_exp  <= '0;
      r_first_got  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every comparison below
      // sees the pre-edge values of r_exp, r_state and r_err_flag.
      r_rd_pend <= r_en;
      if (r_rd_pend) begin
        r_word_count <= r_word_count + 1'b1;
        // On a match exp+1 equals w+1; on a mismatch we re-align to w+1, so one
        // dropped word costs exactly one error. Either way the next expected is w+1.
        r_exp <= r_out + 1'b1;
        if (resync || (r_state == ST_SYNC)) begin
          // This word becomes the lock word; no comparison is made.
          r_state  <= ST_RUN;
          r_locked <= 1'b1;
        end else if (w_mismatch) begin
          if (r_err_count != ERR_MAX) begin
            r_err_count <= r_err_count + 1'b1;
          end
          if (!r_err_flag) begin
            r_err_flag  <= 1'b1;
            r_first_exp <= r_exp;
            r_first_got <= r_out;
          end
        end
      end else if (resync) begin
        r_state  <= ST_SYNC;
        r_locked <= 1'b0;
      end
    end
  end

  assign locked     = r_locked;
  assign word_count = r_word_count;
  assign err_count  = r_err_count;
  assign err_flag   = r_err_flag;
  assign first_exp  = r_first_exp;
  assign first_got  = r_first_got;

endmodule
